// File: rtl/fatori_err_collector.sv
// Fault-event collector: saturating major/minor/scrub counters plus a sticky major alert.
// Define FATORI_ERR_LOG_EN to add the timestamped round-robin event log FIFO and drop counter.
module fatori_err_collector #(
  parameter  int unsigned NUM_MON    = 4,
  parameter  int unsigned CNT_W      = 16,
  parameter  int unsigned TS_W       = 16,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ID_W       = (NUM_MON > 1) ? $clog2(NUM_MON) : 1,
  localparam int unsigned EVT_W      = 2 + ID_W + TS_W
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               clr_i,
  input  logic [NUM_MON-1:0] new_maj_err_i,
  input  logic [NUM_MON-1:0] new_min_err_i,
  input  logic [NUM_MON-1:0] scrub_i,
  output logic [CNT_W-1:0]   maj_cnt_o,
  output logic [CNT_W-1:0]   min_cnt_o,
  output logic [CNT_W-1:0]   scrub_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic               maj_alert_o,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [EVT_W-1:0]   evt_data_o
);

  localparam int unsigned NSRC = 3 * NUM_MON;

  if (NUM_MON < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("fatori_err_collector: NUM_MON must be >= 1 and FIFO_DEPTH a power of two >= 2");
  end

  function automatic int unsigned popcnt(input logic [NSRC-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NSRC; i++) n += 32'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned b);
    logic [CNT_W+31:0] s;
    s = {32'b0, a} + {{CNT_W{1'b0}}, b};
    return (|s[CNT_W+31:CNT_W]) ? '1 : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] maj_cnt_q, maj_cnt_d;
  logic [CNT_W-1:0] min_cnt_q, min_cnt_d;
  logic [CNT_W-1:0] scr_cnt_q, scr_cnt_d;
  logic             alert_q, alert_d;

  always_comb begin
    maj_cnt_d = sat_add(maj_cnt_q, popcnt(NSRC'(new_maj_err_i)));
    min_cnt_d = sat_add(min_cnt_q, popcnt(NSRC'(new_min_err_i)));
    scr_cnt_d = sat_add(scr_cnt_q, popcnt(NSRC'(scrub_i)));
    alert_d   = alert_q | (|new_maj_err_i);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      maj_cnt_q <= '0;
      min_cnt_q <= '0;
      scr_cnt_q <= '0;
      alert_q   <= 1'b0;
    end else if (clr_i) begin
      maj_cnt_q <= '0;
      min_cnt_q <= '0;
      scr_cnt_q <= '0;
      alert_q   <= 1'b0;
    end else begin
      maj_cnt_q <= maj_cnt_d;
      min_cnt_q <= min_cnt_d;
      scr_cnt_q <= scr_cnt_d;
      alert_q   <= alert_d;
    end
  end

  assign maj_cnt_o   = maj_cnt_q;
  assign min_cnt_o   = min_cnt_q;
  assign scrub_cnt_o = scr_cnt_q;
  assign maj_alert_o = alert_q;

`ifdef FATORI_ERR_LOG_EN
  localparam int unsigned PTR_W = $clog2(NSRC);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  logic [NSRC-1:0]  pend_q, pend_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [EVT_W-1:0] mem [FIFO_DEPTH];

  logic [NSRC-1:0]  pulse, log_mask;
  logic [PTR_W-1:0] hi, lo, sel;
  logic             hi_ok, lo_ok, full, log_en, pop;
  logic [1:0]       rec_type;
  logic [ID_W-1:0]  rec_id;
  logic [EVT_W-1:0] wr_rec;

  always_comb begin
    pulse = {scrub_i, new_maj_err_i, new_min_err_i};
    hi_ok = 1'b0;
    lo_ok = 1'b0;
    hi    = '0;
    lo    = '0;
    // Rotating priority: lowest set bit at/after rr_q, else lowest set bit overall.
    for (int unsigned j = 0; j < NSRC; j++) begin
      if (pend_q[j]) begin
        if (!lo_ok) begin
          lo_ok = 1'b1;
          lo    = PTR_W'(j);
        end
        if (!hi_ok && j >= 32'(rr_q)) begin
          hi_ok = 1'b1;
          hi    = PTR_W'(j);
        end
      end
    end
    sel      = hi_ok ? hi : lo;
    full     = (occ_q == (AW+1)'(FIFO_DEPTH));
    log_en   = lo_ok && !full;
    log_mask = log_en ? (NSRC'(1) << sel) : '0;

    rec_type = '0;
    rec_id   = '0;
    for (int unsigned j = 0; j < NSRC; j++) begin
      if (32'(sel) == j) begin
        rec_type = 2'(j / NUM_MON + 1);
        rec_id   = ID_W'(j % NUM_MON);
      end
    end
    wr_rec = {rec_type, rec_id, ts_q};

    // A pulse on the bit being logged re-arms it instead of counting as a drop.
    pend_d     = (pend_q & ~log_mask) | pulse;
    drop_cnt_d = sat_add(drop_cnt_q, popcnt(pulse & pend_q & ~log_mask));
    rr_d       = rr_q;
    if (log_en) rr_d = (32'(sel) == NSRC - 1) ? '0 : sel + 1'b1;
    ts_d = ts_q + 1'b1;

    pop   = (occ_q != '0) && evt_ready_i;
    wr_d  = log_en ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    occ_d = occ_q + (AW+1)'(log_en) - (AW+1)'(pop);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pend_q     <= '0;
      rr_q       <= '0;
      ts_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      drop_cnt_q <= '0;
    end else if (clr_i) begin
      pend_q     <= '0;
      rr_q       <= '0;
      ts_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      ts_q       <= ts_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (log_en && !clr_i) mem[wr_q] <= wr_rec;
  end

  assign drop_cnt_o  = drop_cnt_q;
  assign evt_valid_o = (occ_q != '0);
  assign evt_data_o  = evt_valid_o ? mem[rd_q] : '0;
`else
  logic unused_evt_ready;
  assign unused_evt_ready = evt_ready_i;
  assign drop_cnt_o  = '0;
  assign evt_valid_o = 1'b0;
  assign evt_data_o  = '0;
`endif

endmodule

// File: doc/fatori_err_collector.md
# fatori_err_collector

Fault-event collector that sits at the receiving end of the error-pulse outputs of a bank of `fatori_reg_mon` instances. It counts major-error, minor-error and scrub pulses in saturating counters. It raises a sticky major-error alert. Optionally, it logs each event as a timestamped record into a FIFO that is drained over a valid/ready stream by the fault-injection campaign controller.

## Interface
- NUM_MON, 4: number of monitored registers; must be ≥1.
- CNT_W, 16: width of every event counter.
- TS_W, 16: width of the free-running timestamp.
- FIFO_DEPTH, 8: event log depth; power of two, ≥2.
- Derived: ID_W = max(1, $clog2(NUM_MON)); EVT_W = 2+ID_W+TS_W.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset; asynchronous, active-high.
- clr_i  in  1  synchronous clear of all state.
- new_maj_err_i  in  NUM_MON  one-cycle major-error pulses; bit i comes from monitor i.
- new_min_err_i  in  NUM_MON  one-cycle minor-error pulses.
- scrub_i  in  NUM_MON  one-cycle scrub pulses.
- maj_cnt_o  out  CNT_W  saturating major-event count.
- min_cnt_o  out  CNT_W  saturating minor-event count.
- scrub_cnt_o  out  CNT_W  saturating scrub-event count.
- drop_cnt_o  out  CNT_W  saturating count of events lost to pending-slot collision.
- maj_alert_o  out  1  sticky; set by any major pulse.
- evt_valid_o  out  1  event record available.
- evt_ready_i  in  1  consumer accepts the record.
- evt_data_o  out  EVT_W  record layout {type[1:0], id[ID_W-1:0], ts[TS_W-1:0]}; type encoding: 01 = minor, 10 = major, 11 = scrub.

## Operation
- **Reset values.** arst_i zeroes all counters, maj_alert_o, timestamp, pending bits, round-robin pointer and FIFO. Therefore every output is 0 at reset, including evt_valid_o and evt_data_o.
- **Clear.** clr_i has the same effect as reset, applied at the next edge. It has priority over all other events. Pulses arriving in a clr_i cycle are discarded and are not counted.
- **Counting.**
  - Each cycle, each counter adds the popcount of its pulse vector (0..NUM_MON).
  - Counters saturate at 2^CNT_W−1 and never wrap.
- **Alert.** maj_alert_o is set when any new_maj_err_i bit is 1. It clears only on clr_i or arst_i.
- **Timestamp.** ts_q increments every cycle and wraps modulo 2^TS_W.
- **Pending bits.**
  - There are 3·NUM_MON pending bits. Source index s = type_idx·NUM_MON + id, with type_idx 0 = minor, 1 = major, 2 = scrub.
  - A pulse sets its pending bit.
- **Logging.**
  - Each cycle, if the FIFO is not full, the block selects the first set pending bit at or after the round-robin pointer, wrapping past 3·NUM_MON−1.
  - It writes {type, id, ts_q} to the FIFO and clears that pending bit. The pointer becomes s+1, wrapping to 0 after 3·NUM_MON−1.
  - At most one record is written per cycle.
- **Timestamp meaning.** ts is the log cycle, not the pulse cycle.
  - Skew is at least 1 cycle.
  - It is bounded by 3·NUM_MON cycles while the FIFO has room.
- **Collisions.**
  - A pulse on a pending bit that is set and not being logged this cycle increments drop_cnt_o. The pending bit stays set.
  - A pulse on the bit being logged this cycle leaves the bit set and is not a drop.
- **FIFO full.** No write occurs. Pending bits are held, which is backpressure. No records are lost except through collisions.
- **Output stream.**
  - evt_valid_o = FIFO not empty. evt_data_o = head record; it is 0 when empty.
  - A pop occurs on evt_valid_o & evt_ready_i.
  - Push and pop in the same cycle are allowed. Full status is taken from the registered occupancy, so a full FIFO accepts no push even when a pop happens that cycle.
  - evt_data_o is stable while evt_valid_o & !evt_ready_i.

## Timing
- Pulse sampled at edge t: counters and alert update at edge t; visible in cycle t+1.
- Pending bit set at edge t. The earliest log is at edge t+1, so evt_valid_o rises in cycle t+2. The record ts equals the ts_q value of cycle t+1.
- Throughput: one record per cycle in and one out.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: FATORI_ERR_LOG_EN.
- **Defined:** pending bits, round-robin logger, timestamp, FIFO and drop counter are compiled in, as described above.
- **Undefined:** only maj/min/scrub counters and alert exist.
  - evt_valid_o = 0, evt_data_o = 0, drop_cnt_o = 0.
  - evt_ready_i is ignored.

## Test plan
- **Reset.** Assert arst_i mid-run with the FIFO holding 3 records → every output is 0 immediately; after release, ts restarts at 0.
- **Single minor event.** new_min_err_i[2] pulses in the cycle where ts_q = 5 → min_cnt_o = 1 in the next cycle; evt_data_o = {01, 2, 6}, with evt_valid_o high two cycles after the pulse.
- **Simultaneous majors.** new_maj_err_i = 4'b1111 for one cycle → maj_cnt_o = 4 in one step; maj_alert_o = 1; 4 records with ids 0, 1, 2, 3 on consecutive ts values.
- **Backpressure.** evt_ready_i = 0 with 10 distinct sources pulsed → 8 records stored and 2 pending, drop_cnt_o = 0; raising evt_ready_i drains all 10 in round-robin order.
- **Collision while full.** With the FIFO full, the same scrub_i bit pulses twice → drop_cnt_o = 1; scrub_cnt_o = 2.
- **Saturation and clear.** With CNT_W = 4, 20 minor pulses → min_cnt_o = 15; clr_i together with a pulse in the same cycle → all counters 0 and alert 0; that pulse is not counted.
